// File: rtl/instr_sequencer.sv
// Control sequencer for the 8-bit bus CPU: a six-state one-hot ring (three fetch
// states, then three opcode-dependent execute states) with the datapath control lines decoded from it.
module instr_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       step,
    input  logic [3:0] opcode,
    output logic [5:0] t_state,
    output logic       pc_inc,
    output logic       pc_out,
    output logic       mar_load,
    output logic       ram_out,
    output logic       ir_load,
    output logic       ir_out,
    output logic       a_load,
    output logic       a_out,
    output logic       b_load,
    output logic       alu_out,
    output logic       alu_sub,
    output logic       out_load,
    output logic       halted
);

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    logic [5:0] t_state_reg;
    logic [5:0] t_state_next;
    logic       halted_reg;
    logic       adv;
    logic       halt_now;

    assign adv      = ~halted_reg & (run | step);
    assign halt_now = (t_state_reg == T4) && (opcode == OP_HLT);

    // Ring rotation: each bit takes its lower neighbour, T6 wraps back into T1.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_ring
            if (gi == 0) begin : g_wrap
                assign t_state_next[gi] = t_state_reg[5];
            end else begin : g_shift
                assign t_state_next[gi] = t_state_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            t_state_reg <= T1;
            halted_reg  <= 1'b0;
        end else if (adv) begin
            if (halt_now) begin
                halted_reg <= 1'b1;
            end else begin
                t_state_reg <= t_state_next;
            end
        end
    end

    assign t_state = t_state_reg;
    assign halted  = halted_reg;

    always_comb begin
        pc_inc   = 1'b0;
        pc_out   = 1'b0;
        mar_load = 1'b0;
        ram_out  = 1'b0;
        ir_load  = 1'b0;
        ir_out   = 1'b0;
        a_load   = 1'b0;
        a_out    = 1'b0;
        b_load   = 1'b0;
        alu_out  = 1'b0;
        alu_sub  = 1'b0;
        out_load = 1'b0;
        if (!rst && !halted_reg) begin
            case (t_state_reg)
                T1: begin
                    pc_out   = 1'b1;
                    mar_load = 1'b1;
                end
                T2: pc_inc = 1'b1;
                T3: begin
                    ram_out = 1'b1;
                    ir_load = 1'b1;
                end
                T4: begin
                    if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
                        ir_out   = 1'b1;
                        mar_load = 1'b1;
                    end else if (opcode == OP_OUT) begin
                        a_out    = 1'b1;
                        out_load = 1'b1;
                    end
                end
                T5: begin
                    if (opcode == OP_LDA) begin
                        ram_out = 1'b1;
                        a_load  = 1'b1;
                    end else if (opcode == OP_ADD || opcode == OP_SUB) begin
                        ram_out = 1'b1;
                        b_load  = 1'b1;
                    end
                end
                T6: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        alu_out = 1'b1;
                        a_load  = 1'b1;
                        alu_sub = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed segments followed by random run/step/opcode/reset
// traffic, all checked against a T-state-index model with a table-driven control decode.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       rst, run, step;
    logic [3:0] opcode;
    logic [5:0] t_state;
    logic       pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out;
    logic       a_load, a_out, b_load, alu_out, alu_sub, out_load, halted;

    instr_sequencer dut (
        .clk(clk), .rst(rst), .run(run), .step(step), .opcode(opcode),
        .t_state(t_state), .pc_inc(pc_inc), .pc_out(pc_out), .mar_load(mar_load),
        .ram_out(ram_out), .ir_load(ir_load), .ir_out(ir_out), .a_load(a_load),
        .a_out(a_out), .b_load(b_load), .alu_out(alu_out), .alu_sub(alu_sub),
        .out_load(out_load), .halted(halted)
    );

    always #5 clk = ~clk;

    // Control bit positions in the packed comparison vector.
    localparam int C_PCI = 11, C_PCO = 10, C_MAR = 9, C_RAM = 8, C_IRL = 7, C_IRO = 6;
    localparam int C_AL = 5, C_AO = 4, C_BL = 3, C_ALU = 2, C_SUB = 1, C_OL = 0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: T-state as a number 1..6, plus halt flag.
    int model_t     = 1;
    bit model_halt  = 1'b0;
    bit model_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] exp_ctrl(input int t, input logic [3:0] op,
                                             input bit r, input bit h);
        logic [11:0] c;
        c = '0;
        if (r || h) return c;
        case (t)
            1: begin c[C_PCO] = 1; c[C_MAR] = 1; end
            2: c[C_PCI] = 1;
            3: begin c[C_RAM] = 1; c[C_IRL] = 1; end
            4: if (op <= 4'd2) begin c[C_IRO] = 1; c[C_MAR] = 1; end
               else if (op == 4'hE) begin c[C_AO] = 1; c[C_OL] = 1; end
            5: if (op == 4'h0) begin c[C_RAM] = 1; c[C_AL] = 1; end
               else if (op == 4'h1 || op == 4'h2) begin c[C_RAM] = 1; c[C_BL] = 1; end
            6: if (op == 4'h1 || op == 4'h2) begin
                   c[C_ALU] = 1; c[C_AL] = 1; c[C_SUB] = (op == 4'h2);
               end
            default: ;
        endcase
        return c;
    endfunction

    // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model on the edge.
    task automatic cycle(input bit r, input bit ru, input bit st, input logic [3:0] op);
        logic [11:0] got;
        @(negedge clk);
        rst = r; run = ru; step = st; opcode = op;
        #1;
        got = {pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out,
               a_load, a_out, b_load, alu_out, alu_sub, out_load};
        check("ctrl", {20'd0, got}, {20'd0, exp_ctrl(model_t, op, r, model_halt)});
        if (model_valid) begin
            check("t_state", {26'd0, t_state}, 32'd1 << (model_t - 1));
            check("halted", {31'd0, halted}, {31'd0, model_halt});
        end
        @(posedge clk);
        if (r) begin
            model_t = 1; model_halt = 1'b0; model_valid = 1'b1;
        end else if (model_valid && !model_halt && (ru || st)) begin
            if (model_t == 4 && op == 4'hF) model_halt = 1'b1;
            else model_t = (model_t % 6) + 1;
        end
    endtask

    function automatic logic [3:0] rand_op();
        case ($urandom_range(0, 5))
            0: return 4'h0;
            1: return 4'h1;
            2: return 4'h2;
            3: return 4'hE;
            4: return ($urandom_range(0, 3) == 0) ? 4'hF : 4'h1;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        rst = 1'b1; run = 1'b0; step = 1'b0; opcode = 4'h0;

        cycle(1, 0, 0, 4'h0);
        for (int i = 0; i < 7; i++) cycle(0, 1, 0, 4'h0);
        $display("segment LDA run: checks=%0d", n_checks);

        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 4'h2);
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 4'h2);
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 4'h1);
        $display("segment SUB/ADD run: checks=%0d", n_checks);

        cycle(1, 0, 0, 4'h0);
        for (int i = 0; i < 9; i++) cycle(0, 0, (i == 3 || i == 7), 4'h0);
        cycle(0, 1, 1, 4'h0);
        $display("segment single-step: checks=%0d", n_checks);

        cycle(1, 0, 0, 4'hF);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 4'hF);
        for (int i = 0; i < 22; i++) cycle(0, $urandom_range(0, 1), $urandom_range(0, 1), rand_op());
        cycle(1, 1, 1, 4'hF);
        cycle(0, 0, 0, 4'h0);
        $display("segment halt/reset: checks=%0d", n_checks);

        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 4'h1);
        cycle(1, 1, 0, 4'h1);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 4'h1);
        $display("segment reset during ADD: checks=%0d", n_checks);

        cycle(1, 0, 0, 4'h5);
        for (int i = 0; i < 7; i++) cycle(0, 1, 0, 4'h5);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 4'hE);
        $display("segment NOP/OUT: checks=%0d", n_checks);

        for (int i = 0; i < 3000; i++)
            cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0),
                  $urandom_range(0, 1), rand_op());
        $display("segment random: checks=%0d", n_checks);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Control sequencer that consumes the opcode held in the instruction register and drives its load/output enables (ir_load, ir_out).
- Also drives the other datapath control lines of the 8-bit bus CPU.
- Built around a 6-state one-hot ring counter (T1..T6): a 3-state fetch followed by a 3-state opcode-dependent execute.
- Control outputs are decoded combinationally from the current T-state and the opcode.

Parameters:
OP_LDA, 4'b0000, load accumulator from RAM[addr]
OP_ADD, 4'b0001, A <= A + RAM[addr]
OP_SUB, 4'b0010, A <= A - RAM[addr]
OP_OUT, 4'b1110, output register <= A
OP_HLT, 4'b1111, stop sequencing until reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
run  in  1  1: advance one T-state per cycle; 0: single-step mode
step  in  1  in single-step mode, advance one T-state in each cycle where step=1
opcode  in  4  opcode field from instruction register
t_state  out  6  one-hot ring state, bit0=T1 .. bit5=T6
pc_inc  out  1  program counter increment (Cp)
pc_out  out  1  PC drives bus (Ep)
mar_load  out  1  memory address register load (Lm)
ram_out  out  1  RAM drives bus (Er)
ir_load  out  1  instruction register load from bus
ir_out  out  1  instruction register address field drives bus
a_load  out  1  accumulator load (La)
a_out  out  1  accumulator drives bus (Ea)
b_load  out  1  B register load (Lb)
alu_out  out  1  ALU drives bus (Eu)
alu_sub  out  1  ALU subtract select (Su)
out_load  out  1  output register load (Lo)
halted  out  1  sticky halt flag

Behaviour:
- Advance condition: adv = ~halted & (run | step).
- On each clock edge with adv=1, the ring rotates T1->T2->..->T6->T1. With adv=0 it holds.
- Reset:
  - On a clock edge with rst=1: t_state=6'b000001 (T1), halted=0.
  - While rst=1, all control outputs are forced to 0.
  - Reset has priority over everything, including mid-instruction and halted; the ring restarts at T1 the following cycle.
- Control decode (combinational, unlisted outputs 0):
  - T1: pc_out, mar_load.
  - T2: pc_inc.
  - T3: ram_out, ir_load.
  - T4:
    - LDA/ADD/SUB: ir_out, mar_load.
    - OUT: a_out, out_load.
    - HLT: none.
  - T5:
    - LDA: ram_out, a_load.
    - ADD/SUB: ram_out, b_load.
    - others: none.
  - T6:
    - ADD: alu_out, a_load.
    - SUB: alu_out, a_load, alu_sub.
    - others: none.
  - Undefined opcodes behave as NOP: no controls in T4..T6, ring still cycles.
- Opcode usage:
  - opcode is only decoded in T4..T6; it is valid there because the IR captures on the edge ending T3.
  - opcode is ignored in T1..T3.
- Halt:
  - When in T4 with opcode==OP_HLT and adv would be 1, the edge sets halted=1 and the ring stays at T4.
  - While halted=1: ring frozen, all control outputs 0, and opcode, run and step are ignored. Only rst clears it.
- Step gating:
  - Control outputs are asserted for every cycle spent in a T-state, including held cycles.
  - Downstream registers are edge-loaded, so a held state re-loads identical data; this is acceptable.
- Simultaneous events: rst with step/run → reset wins; step=1 while run=1 → one advance, no double step.
- Latency: one instruction = 6 advancing cycles; in run mode, back-to-back instructions with no gaps.

Test Plan:
- Reset then run=1, opcode=OP_LDA held → t_state sequence 01,02,04,08,10,20,01. Controls:
  - cycle T1: pc_out=mar_load=1.
  - T3: ir_load=ram_out=1.
  - T4: ir_out=mar_load=1.
  - T5: ram_out=a_load=1.
  - T6: all 0.
- Opcode=OP_SUB, run=1 → T5: b_load=ram_out=1; T6: alu_out=a_load=alu_sub=1. Repeat with OP_ADD → identical except alu_sub=0.
- run=0, step pulsed on cycles 3 and 7 from T1 → t_state stays 01 until after cycle 3, becomes 02, stays 02 until after cycle 7, becomes 04; pc_out=mar_load=1 throughout the T1 hold.
- Opcode=OP_HLT, run=1 → after the T4 edge halted=1, t_state=08 frozen for 20+ cycles, all controls 0. Changing opcode/run/step has no effect. rst=1 for one cycle → t_state=01, halted=0.
- rst asserted during T5 of an ADD → controls 0 during the rst cycle, next cycle t_state=01 with pc_out=mar_load=1, no b_load seen.
- Opcode=4'b0101 (undefined) → T4..T6 all controls 0, ring wraps to T1, halted stays 0; OP_OUT → T4: a_out=out_load=1 only.
